// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared types and widths for the trace-encoder connector
package mure_pkg;

    localparam int XLEN        = 64;
    localparam int IRETIRE_LEN = 8;
    localparam int CAUSE_LEN   = 5;
    localparam int ITYPE_LEN   = 3;

    typedef enum logic [ITYPE_LEN-1:0] {
        STD  = 3'd0,
        EXC  = 3'd1,
        INT  = 3'd2,
        ERET = 3'd3,
        NTB  = 3'd4,
        TB   = 3'd5,
        UPD  = 3'd6
    } itype_e;

    typedef enum logic {
        BB_IDLE  = 1'b0,
        BB_ACCUM = 1'b1
    } bb_state_e;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic [XLEN-1:0]        iaddr;
        itype_e                 itype;
        logic                   ilastsize;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [1:0]             priv;
    } block_t;

endpackage

// File: rtl/te_block_builder.sv
// rtl/te_block_builder.sv - merges sequential committed instructions into E-Trace blocks
module te_block_builder #(
    parameter int XLEN        = mure_pkg::XLEN,
    parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
    parameter int CAUSE_LEN   = mure_pkg::CAUSE_LEN
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           valid_i,
    input  logic [mure_pkg::ITYPE_LEN-1:0] itype_i,
    input  logic [XLEN-1:0]                iaddr_i,
    input  logic                           compressed_i,
    input  logic [CAUSE_LEN-1:0]           cause_i,
    input  logic [XLEN-1:0]                tval_i,
    input  logic [1:0]                     priv_i,
    output logic                           valid_o,
    output logic [IRETIRE_LEN-1:0]         iretire_o,
    output logic [XLEN-1:0]                iaddr_o,
    output logic [mure_pkg::ITYPE_LEN-1:0] itype_o,
    output logic                           ilastsize_o,
    output logic [CAUSE_LEN-1:0]           cause_o,
    output logic [XLEN-1:0]                tval_o,
    output logic [1:0]                     priv_o
);
    import mure_pkg::*;

    // Block records are stored at the package widths; module widths must not exceed them.
    localparam int PKG_IRW = mure_pkg::IRETIRE_LEN;
    localparam int PKG_XW  = mure_pkg::XLEN;
    localparam int PKG_CW  = mure_pkg::CAUSE_LEN;
    localparam int CW      = IRETIRE_LEN + 1;
    // Largest count a block may hold before it is force-closed; keeps count+2 from wrapping.
    localparam logic [CW-1:0] LIMIT = CW'((2 ** IRETIRE_LEN) - 3);

    bb_state_e              state_q, state_d;
    logic [IRETIRE_LEN-1:0] count_q, count_d;
    logic [XLEN-1:0]        start_q, start_d;
    logic                   lastsize_q, lastsize_d;
    logic [1:0]             priv_q, priv_d;
    block_t                 pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    block_t                 out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   conflict_q, conflict_d;

    logic          is_trap, retiring, is_std, priv_chg, acc, emit_ev;
    logic [CW-1:0] inc, base_cnt, cnt_next;
    block_t        ev_blk, chg_blk;

    // Classify the current event and build the block it would close, plus the priv-change block.
    always_comb begin
        is_trap  = (itype_i == EXC) || (itype_i == INT);
        retiring = valid_i && !is_trap;
        is_std   = (itype_i == STD);
        priv_chg = (state_q == BB_ACCUM) && (priv_i != priv_q);
        // A priv change closes the open block first, so the event then sees an empty block.
        acc      = (state_q == BB_ACCUM) && !priv_chg;
        inc      = compressed_i ? CW'(1) : CW'(2);
        base_cnt = acc ? CW'(count_q) : '0;
        cnt_next = base_cnt + inc;
        emit_ev  = is_trap || (retiring && !is_std) || (retiring && is_std && (cnt_next > LIMIT));

        ev_blk       = '0;
        ev_blk.itype = itype_e'(itype_i);
        ev_blk.iaddr = PKG_XW'(acc ? start_q : iaddr_i);
        ev_blk.priv  = priv_i;
        if (is_trap) begin
            ev_blk.iretire   = PKG_IRW'(base_cnt);
            ev_blk.ilastsize = lastsize_q;
            ev_blk.cause     = PKG_CW'(cause_i);
            ev_blk.tval      = PKG_XW'(tval_i);
        end else begin
            ev_blk.iretire   = PKG_IRW'(cnt_next);
            ev_blk.ilastsize = ~compressed_i;
        end

        chg_blk           = '0;
        chg_blk.iretire   = PKG_IRW'(count_q);
        chg_blk.iaddr     = PKG_XW'(start_q);
        chg_blk.itype     = STD;
        chg_blk.ilastsize = lastsize_q;
        chg_blk.priv      = priv_q;
    end

    // Next-state and emission decisions; at most one block leaves per cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        start_d    = start_q;
        lastsize_d = lastsize_q;
        priv_d     = priv_q;
        pend_d     = pend_q;
        pend_vld_d = 1'b0;
        out_d      = '0;
        valid_d    = 1'b0;
        conflict_d = conflict_q;

        if (priv_chg) begin
            out_d   = chg_blk;
            valid_d = 1'b1;
            state_d = BB_IDLE;
        end

        if (retiring && is_std) begin
            lastsize_d = ~compressed_i;
        end

        if (emit_ev) begin
            state_d = BB_IDLE;
            if (priv_chg) begin
                pend_d     = ev_blk;
                pend_vld_d = 1'b1;
            end else begin
                out_d   = ev_blk;
                valid_d = 1'b1;
            end
        end else if (retiring && is_std) begin
            count_d = IRETIRE_LEN'(cnt_next);
            state_d = BB_ACCUM;
            if (!acc) begin
                start_d = iaddr_i;
                priv_d  = priv_i;
            end
        end

        // The held block always goes out; a simultaneous closing event is a protocol breach.
        if (pend_vld_q) begin
            out_d   = pend_q;
            valid_d = 1'b1;
            if (emit_ev) begin
                conflict_d = 1'b1;
            end
        end
    end

    // State, pending and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BB_IDLE;
            count_q    <= '0;
            start_q    <= '0;
            lastsize_q <= 1'b0;
            priv_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            start_q    <= start_d;
            lastsize_q <= lastsize_d;
            priv_q     <= priv_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    ap_no_pending_conflict: assert property (@(posedge clk_i) disable iff (!rst_ni) !conflict_q);

    assign valid_o     = valid_q;
    assign iretire_o   = IRETIRE_LEN'(out_q.iretire);
    assign iaddr_o     = XLEN'(out_q.iaddr);
    assign itype_o     = out_q.itype;
    assign ilastsize_o = out_q.ilastsize;
    assign cause_o     = CAUSE_LEN'(out_q.cause);
    assign tval_o      = XLEN'(out_q.tval);
    assign priv_o      = out_q.priv;

endmodule

// File: tb/tb_te_block_builder.sv
// tb/tb_te_block_builder.sv - scoreboard bench for te_block_builder
module tb_te_block_builder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  itype_i = '0;
    logic [63:0] iaddr_i = '0;
    logic        compressed_i = 1'b0;
    logic [4:0]  cause_i = '0;
    logic [63:0] tval_i = '0;
    logic [1:0]  priv_i = '0;
    logic        valid_o;
    logic [3:0]  iretire_o;
    logic [63:0] iaddr_o;
    logic [2:0]  itype_o;
    logic        ilastsize_o;
    logic [4:0]  cause_o;
    logic [63:0] tval_o;
    logic [1:0]  priv_o;

    typedef struct {
        logic [3:0]  iretire;
        logic [63:0] iaddr;
        logic [2:0]  itype;
        logic        ilastsize;
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [1:0]  priv;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    te_block_builder #(.XLEN(64), .IRETIRE_LEN(4), .CAUSE_LEN(5)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .compressed_i(compressed_i), .cause_i(cause_i),
        .tval_i(tval_i), .priv_i(priv_i), .valid_o(valid_o), .iretire_o(iretire_o),
        .iaddr_o(iaddr_o), .itype_o(itype_o), .ilastsize_o(ilastsize_o),
        .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_blk(input int ir, input logic [63:0] a, input int it, input logic ls,
                              input int ca, input logic [63:0] tv, input int pr);
        exp_t e;
        e.iretire = 4'(ir); e.iaddr = a; e.itype = 3'(it); e.ilastsize = ls;
        e.cause = 5'(ca); e.tval = tv; e.priv = 2'(pr);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input int it, input logic [63:0] a, input logic c,
                        input int pr, input int ca, input logic [63:0] tv);
        @(negedge clk);
        valid_i = v; itype_i = 3'(it); iaddr_i = a; compressed_i = c;
        priv_i = 2'(pr); cause_i = 5'(ca); tval_i = tv;
    endtask

    task automatic idle(input int pr);
        step(1'b0, 0, 64'h0, 1'b0, pr, 0, 64'h0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(valid_o), 64'h0);
        chk({tag, "_iretire"}, 64'(iretire_o), 64'h0);
        chk({tag, "_iaddr"}, iaddr_o, 64'h0);
        chk({tag, "_itype"}, 64'(itype_o), 64'h0);
        chk({tag, "_ilastsize"}, 64'(ilastsize_o), 64'h0);
        chk({tag, "_cause"}, 64'(cause_o), 64'h0);
        chk({tag, "_tval"}, tval_o, 64'h0);
        chk({tag, "_priv"}, 64'(priv_o), 64'h0);
    endtask

    // Monitor: every pulse must match the oldest expected block.
    always @(negedge clk) begin
        if (rst_ni && valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: got iaddr 0x%0h itype %0d expected no pulse", iaddr_o, itype_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("iretire", 64'(iretire_o), 64'(e.iretire));
                chk("iaddr", iaddr_o, e.iaddr);
                chk("itype", 64'(itype_o), 64'(e.itype));
                chk("ilastsize", 64'(ilastsize_o), 64'(e.ilastsize));
                chk("cause", 64'(cause_o), 64'(e.cause));
                chk("tval", tval_o, e.tval);
                chk("priv", 64'(priv_o), 64'(e.priv));
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        // Taken branch closes three sequential 32-bit instructions.
        step(1'b1, 0, 64'h8000_0000, 1'b0, 0, 0, 64'h0);
        step(1'b1, 0, 64'h8000_0004, 1'b0, 0, 0, 64'h0);
        step(1'b1, 0, 64'h8000_0008, 1'b0, 0, 0, 64'h0);
        step(1'b1, 5, 64'h8000_000C, 1'b0, 0, 0, 64'h0);
        expect_blk(8, 64'h8000_0000, 5, 1'b1, 0, 64'h0, 0);
        idle(0);

        // Compressed then 32-bit non-taken branch.
        step(1'b1, 0, 64'h100, 1'b1, 0, 0, 64'h0);
        step(1'b1, 4, 64'h102, 1'b0, 0, 0, 64'h0);
        expect_blk(3, 64'h100, 4, 1'b1, 0, 64'h0, 0);

        // Exception excludes the faulting instruction.
        step(1'b1, 0, 64'h200, 1'b1, 0, 0, 64'h0);
        step(1'b1, 0, 64'h202, 1'b1, 0, 0, 64'h0);
        step(1'b1, 1, 64'h204, 1'b0, 0, 2, 64'hDEAD);
        expect_blk(2, 64'h200, 1, 1'b0, 2, 64'hDEAD, 0);
        idle(0);

        // Interrupt with no open block.
        step(1'b0, 2, 64'h300, 1'b0, 0, 7, 64'h0);
        expect_blk(0, 64'h300, 2, 1'b0, 7, 64'h0, 0);
        idle(0);

        // Counter limit: 7th 32-bit instruction reaches 14 > 13.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0, 64'h400 + 64'(4 * i), 1'b0, 0, 0, 64'h0);
            if (i == 6) expect_blk(14, 64'h400, 0, 1'b1, 0, 64'h0, 0);
        end
        step(1'b1, 6, 64'h420, 1'b1, 0, 0, 64'h0);
        expect_blk(3, 64'h41C, 6, 1'b0, 0, 64'h0, 0);
        idle(0);

        // Priv change with a closing instruction: two pulses in consecutive cycles.
        step(1'b1, 0, 64'h500, 1'b0, 0, 0, 64'h0);
        step(1'b1, 0, 64'h504, 1'b0, 0, 0, 64'h0);
        step(1'b1, 3, 64'h508, 1'b0, 3, 0, 64'h0);
        expect_blk(4, 64'h500, 0, 1'b1, 0, 64'h0, 0);
        expect_blk(2, 64'h508, 3, 1'b1, 0, 64'h0, 3);
        idle(3);

        // Priv change with a sequential instruction: it opens the next block.
        step(1'b1, 0, 64'h600, 1'b0, 3, 0, 64'h0);
        step(1'b1, 0, 64'h604, 1'b0, 0, 0, 64'h0);
        expect_blk(2, 64'h600, 0, 1'b1, 0, 64'h0, 3);
        step(1'b1, 5, 64'h608, 1'b0, 0, 0, 64'h0);
        expect_blk(4, 64'h604, 5, 1'b1, 0, 64'h0, 0);
        idle(0);

        // Reset mid-block discards it.
        step(1'b1, 0, 64'h700, 1'b0, 0, 0, 64'h0);
        step(1'b1, 0, 64'h704, 1'b0, 0, 0, 64'h0);
        @(negedge clk);
        rst_ni = 1'b0;
        valid_i = 1'b0; itype_i = '0; iaddr_i = '0;
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        idle(0);
        step(1'b0, 2, 64'h800, 1'b0, 0, 3, 64'h0);
        expect_blk(0, 64'h800, 2, 1'b0, 3, 64'h0, 0);
        idle(0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
